// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV64 pipeline: opcodes, ALU codes, the ID/EX control bundle
// and the source-register usage decode.
package rv_pipe_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SLL  = 4'b0011,
        ALU_SRL  = 4'b0100,
        ALU_SRA  = 4'b0101,
        ALU_SUB  = 4'b0110,
        ALU_BGEU = 4'b0111,
        ALU_XOR  = 4'b1001,
        ALU_BEQ  = 4'b1010,
        ALU_BNE  = 4'b1011
    } alu_op_e;

    // Narrow part of the ID/EX register; the XLEN-wide operands live beside it in the top.
    typedef struct packed {
        logic       valid;
        logic [6:0] opcode;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [3:0] alu_op;
        logic       alu_src;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t ID_EX_NOP = '0;

    function automatic logic uses_rs1(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_LOAD) || (opcode == OP_IMM) ||
               (opcode == OP_BRANCH) || (opcode == OP_STORE);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_BRANCH) || (opcode == OP_STORE);
    endfunction

endpackage

// File: rtl/load_use_hazard.sv
// Combinational load-use detector: a load in EX whose destination is a source
// actually read by the instruction in ID forces a one-cycle stall.
module load_use_hazard
    import rv_pipe_pkg::*;
(
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    input  logic       dec_valid,
    input  logic [6:0] dec_opcode,
    input  logic [4:0] dec_rs1,
    input  logic [4:0] dec_rs2,
    output logic       hazard_detected
);

    logic rs1_match;
    logic rs2_match;

    always_comb begin
        rs1_match       = uses_rs1(dec_opcode) && (ex_rd == dec_rs1);
        rs2_match       = uses_rs2(dec_opcode) && (ex_rd == dec_rs2);
        // x0 is never really written, so a load to x0 cannot create a dependency.
        hazard_detected = ex_valid && ex_memread && (ex_rd != 5'd0) && dec_valid &&
                          (rs1_match || rs2_match);
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, branch squash of the
// wrong-path fetch, and stall/flush/bubble event counters.
module id_ex_pipe
    import rv_pipe_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [6:0]       dec_opcode,
    input  logic [4:0]       dec_rs1,
    input  logic [4:0]       dec_rs2,
    input  logic [4:0]       dec_rd,
    input  logic [XLEN-1:0]  dec_rs1_val,
    input  logic [XLEN-1:0]  dec_rs2_val,
    input  logic [XLEN-1:0]  dec_imm,
    input  logic [3:0]       dec_alu_op,
    input  logic             dec_alu_src,
    input  logic             dec_branch,
    input  logic             dec_memread,
    input  logic             dec_memwrite,
    input  logic             dec_memtoreg,
    input  logic             dec_regwrite,
    input  logic             dec_flush,
    output logic             hazard_detected,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             ex_valid,
    output logic [6:0]       ex_opcode,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [XLEN-1:0]  ex_rs1_val,
    output logic [XLEN-1:0]  ex_rs2_val,
    output logic [XLEN-1:0]  ex_imm,
    output logic [3:0]       ex_alu_op,
    output logic             ex_alu_src,
    output logic             ex_branch,
    output logic             ex_memread,
    output logic             ex_memwrite,
    output logic             ex_memtoreg,
    output logic             ex_regwrite,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    id_ex_ctrl_t      ctrl_d, ctrl_q;
    logic [XLEN-1:0]  rs1_val_d, rs1_val_q;
    logic [XLEN-1:0]  rs2_val_d, rs2_val_q;
    logic [XLEN-1:0]  imm_d, imm_q;
    logic             squash_d, squash_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;
    logic             load_bubble;

    load_use_hazard u_hazard (
        .ex_valid        (ctrl_q.valid),
        .ex_memread      (ctrl_q.memread),
        .ex_rd           (ctrl_q.rd),
        .dec_valid       (dec_valid),
        .dec_opcode      (dec_opcode),
        .dec_rs1         (dec_rs1),
        .dec_rs2         (dec_rs2),
        .hazard_detected (hazard_detected)
    );

    always_comb begin
        pc_write    = ~hazard_detected;
        if_id_write = ~hazard_detected;
        // A stalled branch must not flush: it re-resolves next cycle with forwarded data.
        if_id_flush = dec_valid & dec_branch & dec_flush & ~hazard_detected;
        squash_d    = if_id_flush;
        load_bubble = hazard_detected | squash_q;

        ctrl_d    = ID_EX_NOP;
        rs1_val_d = '0;
        rs2_val_d = '0;
        imm_d     = '0;
        if (!load_bubble) begin
            ctrl_d.valid  = dec_valid;
            ctrl_d.opcode = dec_opcode;
            ctrl_d.rs1    = dec_rs1;
            ctrl_d.rs2    = dec_rs2;
            ctrl_d.rd     = dec_rd;
            ctrl_d.alu_op = dec_alu_op;
            rs1_val_d     = dec_rs1_val;
            rs2_val_d     = dec_rs2_val;
            imm_d         = dec_imm;
            if (dec_valid) begin
                ctrl_d.alu_src  = dec_alu_src;
                ctrl_d.branch   = dec_branch;
                ctrl_d.memread  = dec_memread;
                ctrl_d.memwrite = dec_memwrite;
                ctrl_d.memtoreg = dec_memtoreg;
                ctrl_d.regwrite = dec_regwrite;
            end
        end

        stall_cnt_d  = stall_cnt_q  + {{(CNT_W-1){1'b0}}, hazard_detected};
        flush_cnt_d  = flush_cnt_q  + {{(CNT_W-1){1'b0}}, if_id_flush};
        bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, load_bubble};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q       <= ID_EX_NOP;
            rs1_val_q    <= '0;
            rs2_val_q    <= '0;
            imm_q        <= '0;
            squash_q     <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            rs1_val_q    <= rs1_val_d;
            rs2_val_q    <= rs2_val_d;
            imm_q        <= imm_d;
            squash_q     <= squash_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    always_comb begin
        ex_valid    = ctrl_q.valid;
        ex_opcode   = ctrl_q.opcode;
        ex_rs1      = ctrl_q.rs1;
        ex_rs2      = ctrl_q.rs2;
        ex_rd       = ctrl_q.rd;
        ex_alu_op   = ctrl_q.alu_op;
        ex_alu_src  = ctrl_q.alu_src;
        ex_branch   = ctrl_q.branch;
        ex_memread  = ctrl_q.memread;
        ex_memwrite = ctrl_q.memwrite;
        ex_memtoreg = ctrl_q.memtoreg;
        ex_regwrite = ctrl_q.regwrite;
        ex_rs1_val  = rs1_val_q;
        ex_rs2_val  = rs2_val_q;
        ex_imm      = imm_q;
        stall_cnt   = stall_cnt_q;
        flush_cnt   = flush_cnt_q;
        bubble_cnt  = bubble_cnt_q;
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe; counters are 4 bits wide here so the wrap is reachable.
module tb_id_ex_pipe;
    import rv_pipe_pkg::*;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             dec_valid;
    logic [6:0]       dec_opcode;
    logic [4:0]       dec_rs1, dec_rs2, dec_rd;
    logic [XLEN-1:0]  dec_rs1_val, dec_rs2_val, dec_imm;
    logic [3:0]       dec_alu_op;
    logic             dec_alu_src, dec_branch, dec_memread, dec_memwrite, dec_memtoreg, dec_regwrite;
    logic             dec_flush;
    logic             hazard_detected, pc_write, if_id_write, if_id_flush;
    logic             ex_valid;
    logic [6:0]       ex_opcode;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0]  ex_rs1_val, ex_rs2_val, ex_imm;
    logic [3:0]       ex_alu_op;
    logic             ex_alu_src, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, bubble_cnt;

    int n_pass = 0;
    int n_total = 0;

    id_ex_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_opcode(dec_opcode),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_rs1_val(dec_rs1_val), .dec_rs2_val(dec_rs2_val), .dec_imm(dec_imm),
        .dec_alu_op(dec_alu_op), .dec_alu_src(dec_alu_src), .dec_branch(dec_branch),
        .dec_memread(dec_memread), .dec_memwrite(dec_memwrite), .dec_memtoreg(dec_memtoreg),
        .dec_regwrite(dec_regwrite), .dec_flush(dec_flush),
        .hazard_detected(hazard_detected), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .ex_regwrite(ex_regwrite),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic [3:0] aop, input logic asrc, input logic br,
                         input logic mr, input logic mw, input logic m2r, input logic rw,
                         input logic [XLEN-1:0] v1, input logic [XLEN-1:0] v2,
                         input logic [XLEN-1:0] imm, input logic fl);
        dec_valid = v; dec_opcode = op; dec_rs1 = r1; dec_rs2 = r2; dec_rd = rd;
        dec_alu_op = aop; dec_alu_src = asrc; dec_branch = br; dec_memread = mr;
        dec_memwrite = mw; dec_memtoreg = m2r; dec_regwrite = rw;
        dec_rs1_val = v1; dec_rs2_val = v2; dec_imm = imm; dec_flush = fl;
    endtask

    task automatic set_idle();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 4'd0, 0, 0, 0, 0, 0, 0, '0, '0, '0, 1'b0);
    endtask

    task automatic set_ld(input logic [4:0] rd, input logic [4:0] rs1);
        drive(1'b1, OP_LOAD, rs1, 5'd0, rd, ALU_ADD, 1, 0, 1, 0, 1, 1, 64'h100, '0, '0, 1'b0);
    endtask

    task automatic set_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [XLEN-1:0] v1);
        drive(1'b1, OP_R, rs1, rs2, rd, ALU_ADD, 0, 0, 0, 0, 0, 1, v1, 64'h22, '0, 1'b0);
    endtask

    task automatic set_beq(input logic [4:0] rs1, input logic [4:0] rs2, input logic fl);
        drive(1'b1, OP_BRANCH, rs1, rs2, 5'd0, ALU_BEQ, 0, 1, 0, 0, 0, 0, 64'h7, 64'h7, 64'h40, fl);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_idle();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 4'($urandom),
              1, 1, 1, 1, 1, 1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        step();
        step();
        n_total++; if (ex_valid !== 1'b0) $display("FAIL reset_ex_valid got %0b want 0", ex_valid); else n_pass++;
        n_total++; if ({ex_opcode, ex_rd, ex_rs1, ex_rs2, ex_alu_op} !== 26'd0)
            $display("FAIL reset_ex_fields got %h want 0", {ex_opcode, ex_rd, ex_rs1, ex_rs2, ex_alu_op}); else n_pass++;
        n_total++; if ({ex_rs1_val, ex_rs2_val, ex_imm} !== 192'd0)
            $display("FAIL reset_ex_data got nonzero want 0"); else n_pass++;
        n_total++; if ({ex_alu_src, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite} !== 6'd0)
            $display("FAIL reset_ex_ctrl got %b want 000000",
                     {ex_alu_src, ex_branch, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite}); else n_pass++;
        n_total++; if ({stall_cnt, flush_cnt, bubble_cnt} !== 12'd0)
            $display("FAIL reset_counters got %h want 0", {stall_cnt, flush_cnt, bubble_cnt}); else n_pass++;
        n_total++; if ({pc_write, if_id_write} !== 2'b11)
            $display("FAIL reset_enables got %b want 11", {pc_write, if_id_write}); else n_pass++;
        rst = 1'b0;
        set_idle();
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        set_ld(5'd5, 5'd1);
        step();
        set_add(5'd6, 5'd5, 5'd2, 64'hABCD);
        settle();
        n_total++; if (hazard_detected !== 1'b1) $display("FAIL lu_hazard got %0b want 1", hazard_detected); else n_pass++;
        n_total++; if ({pc_write, if_id_write} !== 2'b00)
            $display("FAIL lu_stall_enables got %b want 00", {pc_write, if_id_write}); else n_pass++;
        step();
        n_total++; if ({ex_valid, ex_regwrite, ex_rd} !== 7'd0)
            $display("FAIL lu_bubble got %h want 0", {ex_valid, ex_regwrite, ex_rd}); else n_pass++;
        n_total++; if (hazard_detected !== 1'b0) $display("FAIL lu_hazard_release got %0b want 0", hazard_detected); else n_pass++;
        step();
        n_total++; if ({ex_valid, ex_rd, ex_alu_op, ex_regwrite} !== {1'b1, 5'd6, 4'b0010, 1'b1})
            $display("FAIL lu_add_in_ex got %h want %h", {ex_valid, ex_rd, ex_alu_op, ex_regwrite},
                     {1'b1, 5'd6, 4'b0010, 1'b1}); else n_pass++;
        n_total++; if (ex_rs1_val !== 64'hABCD) $display("FAIL lu_add_val got %h want abcd", ex_rs1_val); else n_pass++;
        n_total++; if ({stall_cnt, bubble_cnt} !== {4'd1, 4'd1})
            $display("FAIL lu_counts got %h want 11", {stall_cnt, bubble_cnt}); else n_pass++;
        set_idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_ld(5'd5, 5'd1);
        step();
        set_ld(5'd7, 5'd5);
        settle();
        n_total++; if (hazard_detected !== 1'b1) $display("FAIL b2b_load_hazard got %0b want 1", hazard_detected); else n_pass++;
        step();
        step();
        n_total++; if ({ex_valid, ex_memread, ex_rd} !== {1'b1, 1'b1, 5'd7})
            $display("FAIL b2b_second_load got %h want %h", {ex_valid, ex_memread, ex_rd}, {1'b1, 1'b1, 5'd7}); else n_pass++;
        set_add(5'd8, 5'd7, 5'd1, 64'h1);
        settle();
        n_total++; if (hazard_detected !== 1'b1) $display("FAIL b2b_add_hazard got %0b want 1", hazard_detected); else n_pass++;
        step();
        step();
        set_add(5'd9, 5'd7, 5'd8, 64'h2);
        settle();
        n_total++; if (hazard_detected !== 1'b0) $display("FAIL b2b_no_second_bubble got %0b want 0", hazard_detected); else n_pass++;
        step();
        n_total++; if ({ex_valid, ex_rd, stall_cnt, bubble_cnt} !== {1'b1, 5'd9, 4'd2, 4'd2})
            $display("FAIL b2b_counts got %h want %h", {ex_valid, ex_rd, stall_cnt, bubble_cnt},
                     {1'b1, 5'd9, 4'd2, 4'd2}); else n_pass++;
        set_idle();
    endtask

    task automatic test_no_false_hazard();
        do_reset();
        set_ld(5'd0, 5'd1);
        step();
        set_add(5'd6, 5'd0, 5'd2, 64'h3);
        settle();
        n_total++; if (hazard_detected !== 1'b0) $display("FAIL nf_rd_zero got %0b want 0", hazard_detected); else n_pass++;
        set_ld(5'd5, 5'd1);
        step();
        drive(1'b1, OP_IMM, 5'd7, 5'd5, 5'd6, ALU_ADD, 1, 0, 0, 0, 0, 1, 64'h9, '0, 64'h1, 1'b0);
        settle();
        n_total++; if (hazard_detected !== 1'b0) $display("FAIL nf_addi_rs2 got %0b want 0", hazard_detected); else n_pass++;
        step();
        n_total++; if ({ex_valid, ex_rd, ex_imm[7:0], bubble_cnt} !== {1'b1, 5'd6, 8'h01, 4'd0})
            $display("FAIL nf_addi_in_ex got %h want %h", {ex_valid, ex_rd, ex_imm[7:0], bubble_cnt},
                     {1'b1, 5'd6, 8'h01, 4'd0}); else n_pass++;
        set_idle();
    endtask

    task automatic test_branch_flush();
        do_reset();
        set_beq(5'd1, 5'd2, 1'b1);
        settle();
        n_total++; if (if_id_flush !== 1'b1) $display("FAIL bf_flush got %0b want 1", if_id_flush); else n_pass++;
        step();
        n_total++; if ({ex_valid, ex_branch, ex_alu_op, flush_cnt} !== {1'b1, 1'b1, 4'b1010, 4'd1})
            $display("FAIL bf_beq_in_ex got %h want %h", {ex_valid, ex_branch, ex_alu_op, flush_cnt},
                     {1'b1, 1'b1, 4'b1010, 4'd1}); else n_pass++;
        set_add(5'd9, 5'd3, 5'd4, 64'h55);
        step();
        n_total++; if ({ex_valid, ex_rd, ex_regwrite, bubble_cnt} !== {1'b0, 5'd0, 1'b0, 4'd1})
            $display("FAIL bf_squash_bubble got %h want %h", {ex_valid, ex_rd, ex_regwrite, bubble_cnt},
                     {1'b0, 5'd0, 1'b0, 4'd1}); else n_pass++;
        step();
        n_total++; if ({ex_valid, ex_rd} !== {1'b1, 5'd9})
            $display("FAIL bf_after_squash got %h want %h", {ex_valid, ex_rd}, {1'b1, 5'd9}); else n_pass++;
        set_idle();
    endtask

    task automatic test_branch_stall();
        do_reset();
        set_ld(5'd3, 5'd1);
        step();
        set_beq(5'd3, 5'd4, 1'b1);
        settle();
        n_total++; if ({hazard_detected, if_id_flush} !== 2'b10)
            $display("FAIL bs_no_flush got %b want 10", {hazard_detected, if_id_flush}); else n_pass++;
        step();
        n_total++; if ({ex_valid, flush_cnt, if_id_flush} !== {1'b0, 4'd0, 1'b1})
            $display("FAIL bs_reresolve got %h want %h", {ex_valid, flush_cnt, if_id_flush},
                     {1'b0, 4'd0, 1'b1}); else n_pass++;
        step();
        n_total++; if ({ex_branch, flush_cnt} !== {1'b1, 4'd1})
            $display("FAIL bs_beq_in_ex got %h want %h", {ex_branch, flush_cnt}, {1'b1, 4'd1}); else n_pass++;
        set_idle();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_ld(5'd5, 5'd1);
            step();
            set_add(5'd6, 5'd5, 5'd2, 64'h0);
            step();
            if (i == 14) begin
                n_total++; if (stall_cnt !== 4'hF) $display("FAIL wrap_all_ones got %h want f", stall_cnt); else n_pass++;
            end
        end
        n_total++; if (stall_cnt !== 4'h0) $display("FAIL wrap_to_zero got %h want 0", stall_cnt); else n_pass++;
        set_idle();
    endtask

    task automatic test_reset_mid_squash();
        do_reset();
        set_beq(5'd1, 5'd2, 1'b1);
        step();
        rst = 1'b1;
        set_add(5'd9, 5'd3, 5'd4, 64'h77);
        step();
        n_total++; if ({ex_valid, ex_branch, flush_cnt, bubble_cnt} !== 10'd0)
            $display("FAIL rsq_cleared got %h want 0", {ex_valid, ex_branch, flush_cnt, bubble_cnt}); else n_pass++;
        rst = 1'b0;
        step();
        n_total++; if ({ex_valid, ex_rd, bubble_cnt} !== {1'b1, 5'd9, 4'd0})
            $display("FAIL rsq_no_pending got %h want %h", {ex_valid, ex_rd, bubble_cnt},
                     {1'b1, 5'd9, 4'd0}); else n_pass++;
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_back_to_back();
        test_no_false_hazard();
        test_branch_flush();
        test_branch_stall();
        test_counter_wrap();
        test_reset_mid_squash();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
